// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
package wb_pkg;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  localparam logic [4:0] LINK_REG = 5'd31;
  localparam int         MAX_PUSH = 3;
endpackage

// File: rtl/writeback_sequencer_if.sv
// Core-side bundle of the writeback sequencer: write requests, register-file port, forwarding.
interface writeback_sequencer_if;
  logic        pri_we;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        JAL;
  logic [31:0] pcadd4;
  logic        md_valid, md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        Stall;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WBData;
  logic [4:0]  q_addr1, q_addr2;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;
  logic        Err;

  modport master (
    output pri_we, pri_addr, pri_data, JAL, pcadd4, md_valid, md_addr, md_data, q_addr1, q_addr2,
    input  md_ready, Stall, RegWrite, WriteAddr, WBData, hit1, hit2, fwd1, fwd2, Err
  );
  modport slave (
    input  pri_we, pri_addr, pri_data, JAL, pcadd4, md_valid, md_addr, md_data, q_addr1, q_addr2,
    output md_ready, Stall, RegWrite, WriteAddr, WBData, hit1, hit2, fwd1, fwd2, Err
  );
endinterface

// File: rtl/wb_fifo.sv
// Pending-write circular buffer: up to MAX_PUSH ordered pushes and one pop per cycle.
// Entries are exposed oldest-first (ent[0] is the head) for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [1:0]                push_cnt,
  input  wb_req_t [MAX_PUSH-1:0]    push_req,
  input  logic                      pop,
  output logic [AW:0]               count,
  output wb_req_t [DEPTH-1:0]       ent,
  output logic [DEPTH-1:0]          ent_vld
);
  wb_req_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push_cnt) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; a zero count makes stale entries invisible.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < MAX_PUSH; k++)
      if (2'(k) < push_cnt) mem[wr_ptr + AW'(k)] <= push_req[k];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i]     = mem[rd_ptr + AW'(i)];
      ent_vld[i] = (AW+1)'(i) < count;
    end
  end
endmodule

// File: rtl/writeback_sequencer.sv
// Serializes datapath, link and mult/div writes onto the single register-file write port,
// with back-pressure, sticky overrun error and forwarding from not-yet-committed writes.
module writeback_sequencer
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  writeback_sequencer_if.slave   wb
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]              count;
  wb_req_t [DEPTH-1:0]      ent;
  logic [DEPTH-1:0]         ent_vld;
  wb_req_t [MAX_PUSH-1:0]   req, push_req;
  logic [MAX_PUSH-1:0]      req_v;
  wb_req_t [MAX_PUSH:0]     slot;
  logic [1:0]               nreq, push_cnt;
  logic                     stall, empty, bypass, nxt_we;
  wb_req_t                  nxt_out, out_q;
  logic                     we_q, err_q;

  assign stall = count > (AW+1)'(DEPTH - 3);
  assign empty = (count == '0);

  // Compact the accepted requests into program order (pri, link, md); r0 writes vanish here.
  // With an empty buffer the oldest request goes straight out, so a lone link or md
  // write still issues on the next edge.
  always_comb begin
    req[0]   = '{addr: wb.pri_addr, data: wb.pri_data};
    req[1]   = '{addr: LINK_REG,    data: wb.pcadd4};
    req[2]   = '{addr: wb.md_addr,  data: wb.md_data};
    req_v[0] = ~stall & wb.pri_we & (|wb.pri_addr);
    req_v[1] = ~stall & wb.JAL;
    req_v[2] = ~stall & wb.md_valid & (|wb.md_addr);
    slot = '0;
    nreq = '0;
    for (int k = 0; k < MAX_PUSH; k++)
      if (req_v[k]) begin
        slot[nreq] = req[k];
        nreq       = nreq + 2'd1;
      end
    bypass = empty & (nreq != 2'd0);
    for (int j = 0; j < MAX_PUSH; j++)
      push_req[j] = slot[2'(j) + 2'(bypass)];
    push_cnt = nreq - 2'(bypass);
    nxt_we   = ~empty | (nreq != 2'd0);
    nxt_out  = empty ? slot[0] : ent[0];
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push_cnt (push_cnt),
    .push_req (push_req),
    .pop      (~empty),
    .count    (count),
    .ent      (ent),
    .ent_vld  (ent_vld)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q  <= 1'b0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      we_q <= nxt_we;
      if (nxt_we) out_q <= nxt_out;
      if (stall && (wb.pri_we || wb.JAL)) err_q <= 1'b1;
    end
  end

  // Output register is the oldest pending write; later buffer entries override it.
  function automatic logic [32:0] lookup(input logic [4:0] q, input logic ow, input wb_req_t o,
                                         input wb_req_t [DEPTH-1:0] e, input logic [DEPTH-1:0] v);
    lookup = '0;
    if (ow && o.addr == q) lookup = {1'b1, o.data};
    for (int i = 0; i < DEPTH; i++)
      if (v[i] && e[i].addr == q) lookup = {1'b1, e[i].data};
    if (q == 5'd0) lookup = '0;
  endfunction

  assign {wb.hit1, wb.fwd1} = lookup(wb.q_addr1, we_q, out_q, ent, ent_vld);
  assign {wb.hit2, wb.fwd2} = lookup(wb.q_addr2, we_q, out_q, ent, ent_vld);

  assign wb.Stall     = stall;
  assign wb.md_ready  = ~stall;
  assign wb.RegWrite  = we_q;
  assign wb.WriteAddr = out_q.addr;
  assign wb.WBData    = out_q.data;
  assign wb.Err       = err_q;
endmodule
